alu_pipe_unit: RTL and testbench
================================

Name: alu_pipe_unit

Overview:
- Parametrised successor of the single-entry ALU execution block.
- Accepts one issued ALU op per cycle, tagged with a destination register and ROB id.
- Computes the result in the issue cycle, delays it through LAT-1 further stages, and queues completed results in a WB_DEPTH-entry writeback FIFO drained by an active-low req/ack handshake.
- Supports flush, 64/32-bit (word) mode, and back-pressure via busy.

Parameters:
- DATA, 64, operand/result width (multiple of 32, >=64).
- ROB_DEPTH, 32, ROB entries; ROB = $clog2(ROB_DEPTH).
- RD_W, 6, destination register descriptor width (regtype+addr, opaque).
- LAT, 2, issue-to-FIFO latency in cycles (1..4).
- WB_DEPTH, 4, writeback FIFO entries (power of 2, >=2).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- flush_  in  1  active-low; kills all in-flight and queued ops.
- issue_e_  in  1  active-low issue strobe.
- rd  in  RD_W  destination descriptor.
- rob_id  in  ROB  ROB tag of the issued op.
- data1_e_  in  1  active-low; high selects the forwarded operand.
- data1  in  DATA  operand 1.
- data2  in  DATA  operand 2.
- op  in  3  0=ADD, 1=SUB, 2=COMP, 3=SHIFT, 4=LOGIC; 5-7 reserved.
- sub_op  in  4  [0]=word, [1]=unsigned/right, [2]=lt/arith, [3]=neg.
- busy  out  1  high: next issue would overflow.
- wb_req_  out  1  active-low; FIFO head valid.
- wb_ack_  in  1  active-low; pops the head.
- wb_e_  out  1  active-low; head transferred this cycle.
- wb_rd  out  RD_W  head destination.
- wb_rob_id  out  ROB  head ROB tag.
- wb_data  out  DATA  head result.

Behaviour:
- Reset values: busy=0, wb_req_=1, wb_e_=1, wb_rd=0, wb_rob_id=0, wb_data=0. All stage valids, FIFO pointers/count and the forward register clear.
- Compute, in the issue cycle, combinationally:
  - ADD: a+b. SUB: a-b.
  - COMP: result = {0…,flag}. flag = lt ? (a<b, signed unless unsigned) : (a==b); then inverted if neg.
  - SHIFT: amount = b[5:0] (b[4:0] in word mode); direction from right, arithmetic fill from arith.
  - LOGIC: sub_op[2:1] selects 0=AND, 1=OR, 2=XOR; result inverted if neg.
  - Word mode: operate on [31:0], sign-extend the 32-bit result to DATA.
  - Reserved op: result 0; no exception.
- Pipeline: the result is registered at stage 1, then moves through stages 2..LAT. Stage LAT writes the FIFO. Issue at cycle N gives wb_req_ low at N+LAT if the FIFO was empty.
- Forwarding: the forward register loads every issued result at the end of its issue cycle. data1_e_=1 uses it as operand 1, so back-to-back dependency has zero bubbles.
- FIFO:
  - wb_req_ = ~(count!=0). Head fields drive wb_rd/wb_rob_id/wb_data combinationally.
  - wb_e_ = wb_req_ | wb_ack_. A pop occurs when wb_e_ is low.
  - Push and pop in the same cycle: count unchanged, pointers both advance, wrap modulo WB_DEPTH.
  - wb_ack_ low while empty: ignored.
- Occupancy: busy = (count + valid stages − (pop this cycle)) >= WB_DEPTH. Busy is registered-free combinational.
- Issue while busy: dropped, no state change. This is a protocol violation, flagged by an assertion in sim.
- Flush (flush_=0):
  - Next edge clears all stage valids and the FIFO.
  - wb_e_ forced high that cycle.
  - The forward register is kept.
  - An issue in the flush cycle is discarded.
- Reset has priority over flush. Reset mid-stream discards everything.
- Ordering: results leave strictly in issue order.

Optional Feature:
- ALU_PIPE_FWD_EN.
- Defined: the data1_e_ forwarding path exists as described.
- Undefined: no forward register; data1 is always used and data1_e_ is ignored.

Test Plan:
- LAT=2, WB_DEPTH=4, issue ADD 10+(-1), rd=2, rob_id=2, wb_ack_ held low -> wb_e_ low exactly 2 cycles later, wb_data=9, wb_rob_id=2.
- Issue ADD 10+(-1), then next cycle ADD fwd+(-1) with data1_e_=1 -> two writebacks in order, data 9 then 8.
- Word ADD data1=0x7FFFFFFF, data2=1 -> wb_data=0xFFFFFFFF80000000.
- wb_ack_ held high, issue 4 ops -> busy high after the 4th accepted. A 5th issue is dropped. Release ack -> 4 writebacks in order, busy low after the first pop.
- COMP lt unsigned (-1,10) -> 0. COMP lt signed (-1,10) -> 1. SHIFT right arith 0x8000…0>>15 -> 0xFFFF000000000000. LOGIC AND+neg 0xA,0xF -> 0xFFFF…FFF5.
- 3 ops queued, flush_ low for 1 cycle with a simultaneous issue -> wb_req_ high the next cycle, no writeback of any of the 4 ops.

Source files
------------

// File: rtl/alu_pipe_unit.sv
// alu_pipe_unit: issue-cycle ALU, LAT-deep result pipe and in-order writeback FIFO with active-low req/ack.
// Defining ALU_PIPE_FWD_EN adds the data1 forward register selected by data1_e_.
module alu_pipe_unit #(
  parameter int DATA = 64,
  parameter int ROB_DEPTH = 32,
  parameter int RD_W = 6,
  parameter int LAT = 2,
  parameter int WB_DEPTH = 4,
  localparam int ROB = $clog2(ROB_DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush_,
  input  logic            issue_e_,
  input  logic [RD_W-1:0] rd,
  input  logic [ROB-1:0]  rob_id,
  input  logic            data1_e_,
  input  logic [DATA-1:0] data1,
  input  logic [DATA-1:0] data2,
  input  logic [2:0]      op,
  input  logic [3:0]      sub_op,
  output logic            busy,
  output logic            wb_req_,
  input  logic            wb_ack_,
  output logic            wb_e_,
  output logic [RD_W-1:0] wb_rd,
  output logic [ROB-1:0]  wb_rob_id,
  output logic [DATA-1:0] wb_data
);
  localparam int PW = $clog2(WB_DEPTH);
  localparam int CW = $clog2(WB_DEPTH + LAT) + 1;
  logic acc, push, pop, p_v, flag;
  logic [RD_W-1:0] p_rd;
  logic [ROB-1:0] p_rob;
  logic [DATA-1:0] a, b, full, res, p_data;
  logic signed [DATA-1:0] sra;
  logic signed [31:0] sraw;
  logic [31:0] aw, bw, shw;
  logic [5:0] sh;
  logic [CW-1:0] n_stg;
  logic [PW-1:0] wp_q, rp_q;
  logic [PW:0] cnt_q, cnt_d;
  logic [RD_W-1:0] f_rd_q [WB_DEPTH];
  logic [ROB-1:0] f_rob_q [WB_DEPTH];
  logic [DATA-1:0] f_data_q [WB_DEPTH];
`ifdef ALU_PIPE_FWD_EN
  logic [DATA-1:0] fwd_q;
  assign a = data1_e_ ? fwd_q : data1;
  always_ff @(posedge clk)
    if (reset) fwd_q <= '0;
    else if (acc) fwd_q <= res;
`else
  logic unused_fwd;
  assign a = data1;
  assign unused_fwd = data1_e_;
`endif
  assign b = data2;
  assign acc = ~issue_e_ & ~busy & flush_;
  always_comb begin
    aw = a[31:0];
    bw = b[31:0];
    sh = sub_op[0] ? {1'b0, b[4:0]} : b[5:0];
    sra = $signed(a) >>> sh;
    sraw = $signed(aw) >>> sh[4:0];
    shw = sub_op[1] ? (sub_op[2] ? sraw : aw >> sh[4:0]) : aw << sh[4:0];
    flag = sub_op[2] ? (sub_op[0] ? (sub_op[1] ? aw < bw : $signed(aw) < $signed(bw))
                                  : (sub_op[1] ? a < b : $signed(a) < $signed(b)))
                     : (sub_op[0] ? aw == bw : a == b);
    full = '0;
    case (op)
      3'd0: full = a + b;
      3'd1: full = a - b;
      3'd2: full = DATA'(flag ^ sub_op[3]);
      3'd3: full = sub_op[0] ? DATA'(shw) : sub_op[1] ? (sub_op[2] ? sra : a >> sh) : a << sh;
      3'd4: full = {DATA{sub_op[3]}} ^ (sub_op[2:1] == 2'd0 ? a & b : sub_op[2:1] == 2'd1 ? a | b :
                                        sub_op[2:1] == 2'd2 ? a ^ b : '0);
      default: full = '0;
    endcase
    res = sub_op[0] ? {{(DATA-32){full[31]}}, full[31:0]} : full;
  end
  // The FIFO itself acts as stage LAT, so only LAT-1 register stages precede it.
  if (LAT == 1) begin : g_direct
    assign p_v = acc;
    assign p_rd = rd;
    assign p_rob = rob_id;
    assign p_data = res;
    assign n_stg = '0;
  end else begin : g_stages
    logic [LAT-2:0] v_q;
    logic [RD_W-1:0] rd_q [LAT-1];
    logic [ROB-1:0] rob_q [LAT-1];
    logic [DATA-1:0] d_q [LAT-1];
    always_ff @(posedge clk) begin
      v_q <= (reset || !flush_) ? '0 : (LAT-1)'({v_q, acc});
      rd_q[0] <= rd;
      rob_q[0] <= rob_id;
      d_q[0] <= res;
      for (int i = 1; i < LAT-1; i++) begin
        rd_q[i] <= rd_q[i-1];
        rob_q[i] <= rob_q[i-1];
        d_q[i] <= d_q[i-1];
      end
    end
    assign p_v = v_q[LAT-2];
    assign p_rd = rd_q[LAT-2];
    assign p_rob = rob_q[LAT-2];
    assign p_data = d_q[LAT-2];
    assign n_stg = CW'($countones(v_q));
  end
  assign wb_req_ = cnt_q == '0;
  assign wb_e_ = wb_req_ | wb_ack_ | ~flush_;
  assign pop = ~wb_e_;
  assign push = p_v & flush_;
  assign busy = CW'(cnt_q) + n_stg - CW'(pop) >= CW'(WB_DEPTH);
  assign cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
  assign wb_rd = wb_req_ ? '0 : f_rd_q[rp_q];
  assign wb_rob_id = wb_req_ ? '0 : f_rob_q[rp_q];
  assign wb_data = wb_req_ ? '0 : f_data_q[rp_q];
  always_ff @(posedge clk) begin
    if (reset || !flush_) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= wp_q + PW'(push);
      rp_q <= rp_q + PW'(pop);
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk)
    if (push) begin
      f_rd_q[wp_q] <= p_rd;
      f_rob_q[wp_q] <= p_rob;
      f_data_q[wp_q] <= p_data;
    end
  a_issue_busy: assert property (@(posedge clk) disable iff (reset) !(!issue_e_ && flush_ && busy))
    else $error("alu_pipe_unit: issue while busy was dropped");
endmodule

// File: tb/tb_alu_pipe_unit.sv
// tb_alu_pipe_unit: directed vector table, hand-written corner sequences and random traffic
// checked against a queue-based model of the ALU pipe and writeback FIFO.
module tb_alu_pipe_unit;
  localparam int LAT = 2, WB = 4, RD_W = 6, ROB = 5, NV = 17;
`ifdef ALU_PIPE_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset, flush_, issue_e_, data1_e_, wb_ack_;
  logic [RD_W-1:0] rd;
  logic [ROB-1:0] rob_id;
  logic [63:0] data1, data2;
  logic [2:0] op;
  logic [3:0] sub_op;
  logic busy, wb_req_, wb_e_;
  logic [RD_W-1:0] wb_rd;
  logic [ROB-1:0] wb_rob_id;
  logic [63:0] wb_data;
  int checks = 0, failures = 0, cyc = 0;
  typedef struct {logic [RD_W-1:0] rd; logic [ROB-1:0] rob; logic [63:0] data; int rdy;} ent_t;
  typedef struct {logic [2:0] op; logic [3:0] so; logic [63:0] a; logic [63:0] b; logic [63:0] exp;} vec_t;
  ent_t mq[$];
  vec_t tab[NV];
  logic [63:0] fwd_m = '0;

  always #5 clk = ~clk;

  alu_pipe_unit #(.DATA(64), .ROB_DEPTH(32), .RD_W(RD_W), .LAT(LAT), .WB_DEPTH(WB)) dut (
    .clk(clk), .reset(reset), .flush_(flush_), .issue_e_(issue_e_), .rd(rd), .rob_id(rob_id),
    .data1_e_(data1_e_), .data1(data1), .data2(data2), .op(op), .sub_op(sub_op), .busy(busy),
    .wb_req_(wb_req_), .wb_ack_(wb_ack_), .wb_e_(wb_e_), .wb_rd(wb_rd), .wb_rob_id(wb_rob_id),
    .wb_data(wb_data));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] ref_alu(input logic [2:0] o, input logic [3:0] so,
                                          input logic [63:0] a, input logic [63:0] b);
    logic w;
    logic [63:0] sa, za, sb, zb, r;
    int n;
    w = so[0];
    sa = w ? {{32{a[31]}}, a[31:0]} : a;
    za = w ? {32'd0, a[31:0]} : a;
    sb = w ? {{32{b[31]}}, b[31:0]} : b;
    zb = w ? {32'd0, b[31:0]} : b;
    n = w ? int'(b[4:0]) : int'(b[5:0]);
    r = '0;
    if (o == 3'd0) r = a + b;
    else if (o == 3'd1) r = a - b;
    else if (o == 3'd2) begin
      if (so[2]) r[0] = so[1] ? (za < zb) : ($signed(sa) < $signed(sb));
      else r[0] = (za == zb);
      r[0] = r[0] ^ so[3];
    end else if (o == 3'd3) begin
      if (!so[1]) r = a << n;
      else if (so[2]) r = $signed(sa) >>> n;
      else r = za >> n;
    end else if (o == 3'd4) begin
      if (so[2:1] == 2'd0) r = a & b;
      else if (so[2:1] == 2'd1) r = a | b;
      else if (so[2:1] == 2'd2) r = a ^ b;
      if (so[3]) r = ~r;
    end
    if (w) r = {{32{r[31]}}, r[31:0]};
    return r;
  endfunction

  function automatic bit m_busy();
    bit pp;
    pp = mq.size() > 0 && mq[0].rdy <= cyc && !wb_ack_ && flush_;
    return (mq.size() - int'(pp)) >= WB;
  endfunction

  task automatic model_cycle();
    bit hv, pp, bz;
    ent_t e;
    hv = mq.size() > 0 && mq[0].rdy <= cyc;
    pp = hv && !wb_ack_ && flush_;
    bz = (mq.size() - int'(pp)) >= WB;
    chk("m_wb_req_", wb_req_, !hv);
    chk("m_wb_e_", wb_e_, !pp);
    chk("m_busy", busy, bz);
    if (hv) begin
      chk("m_wb_data", wb_data, mq[0].data);
      chk("m_wb_rd", wb_rd, mq[0].rd);
      chk("m_wb_rob_id", wb_rob_id, mq[0].rob);
    end
    if (reset) begin
      mq.delete();
      fwd_m = '0;
    end else if (!flush_) mq.delete();
    else begin
      if (pp) void'(mq.pop_front());
      if (!issue_e_ && !bz) begin
        e.data = ref_alu(op, sub_op, (FWD_EN && data1_e_) ? fwd_m : data1, data2);
        e.rd = rd;
        e.rob = rob_id;
        e.rdy = cyc + LAT;
        mq.push_back(e);
        fwd_m = e.data;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic issue(input logic [2:0] o, input logic [3:0] s, input logic [63:0] a,
                       input logic [63:0] b, input int tag, input logic fw);
    issue_e_ = 1'b0;
    op = o;
    sub_op = s;
    data1 = a;
    data2 = b;
    rd = RD_W'(tag);
    rob_id = ROB'(tag);
    data1_e_ = fw;
  endtask

  task automatic idle();
    issue_e_ = 1'b1;
    data1_e_ = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tab[0]  = '{3'd0, 4'b0000, 64'd10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd9};
    tab[1]  = '{3'd1, 4'b0000, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE};
    tab[2]  = '{3'd0, 4'b0001, 64'h7FFF_FFFF, 64'd1, 64'hFFFF_FFFF_8000_0000};
    tab[3]  = '{3'd2, 4'b0110, 64'hFFFF_FFFF_FFFF_FFFF, 64'd10, 64'd0};
    tab[4]  = '{3'd2, 4'b0100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd10, 64'd1};
    tab[5]  = '{3'd3, 4'b0110, 64'h8000_0000_0000_0000, 64'd15, 64'hFFFF_0000_0000_0000};
    tab[6]  = '{3'd4, 4'b1000, 64'hA, 64'hF, 64'hFFFF_FFFF_FFFF_FFF5};
    tab[7]  = '{3'd2, 4'b1000, 64'd5, 64'd5, 64'd0};
    tab[8]  = '{3'd3, 4'b0001, 64'd1, 64'd31, 64'hFFFF_FFFF_8000_0000};
    tab[9]  = '{3'd3, 4'b0001, 64'd1, 64'h20, 64'd1};
    tab[10] = '{3'd3, 4'b0000, 64'd1, 64'h20, 64'h1_0000_0000};
    tab[11] = '{3'd5, 4'b0000, 64'd3, 64'd4, 64'd0};
    tab[12] = '{3'd4, 4'b0100, 64'hF0, 64'hFF, 64'h0F};
    tab[13] = '{3'd3, 4'b0011, 64'hFFFF_FFFF_8000_0000, 64'd4, 64'h0800_0000};
    tab[14] = '{3'd1, 4'b0001, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF};
    tab[15] = '{3'd4, 4'b0010, 64'hF0, 64'h0F, 64'hFF};
    tab[16] = '{3'd2, 4'b0001, 64'h1_0000_0005, 64'd5, 64'd1};
    reset = 1'b1;
    flush_ = 1'b1;
    issue_e_ = 1'b1;
    data1_e_ = 1'b0;
    wb_ack_ = 1'b1;
    rd = '0;
    rob_id = '0;
    data1 = '0;
    data2 = '0;
    op = '0;
    sub_op = '0;
    @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_wb_req_", wb_req_, 1'b1);
    chk("rst_wb_e_", wb_e_, 1'b1);
    chk("rst_wb_rd", wb_rd, '0);
    chk("rst_wb_rob_id", wb_rob_id, '0);
    chk("rst_wb_data", wb_data, '0);
    tick();
    reset = 1'b0;
    wb_ack_ = 1'b0;
    issue(3'd0, 4'b0000, 64'd10, 64'hFFFF_FFFF_FFFF_FFFF, 2, 1'b0);
    tick();
    idle();
    #1;
    chk("lat_early_wb_e_", wb_e_, 1'b1);
    tick();
    #1;
    chk("lat_wb_e_", wb_e_, 1'b0);
    chk("lat_wb_data", wb_data, 64'd9);
    chk("lat_wb_rob_id", wb_rob_id, 64'd2);
    tick();
    issue(3'd0, 4'b0000, 64'd10, 64'hFFFF_FFFF_FFFF_FFFF, 3, 1'b0);
    tick();
    issue(3'd0, 4'b0000, 64'd100, 64'hFFFF_FFFF_FFFF_FFFF, 4, 1'b1);
    tick();
    idle();
    #1;
    chk("fwd_first", wb_data, 64'd9);
    tick();
    #1;
    chk("fwd_second", wb_data, FWD_EN ? 64'd8 : 64'd99);
    chk("fwd_second_rob", wb_rob_id, 64'd4);
    tick();
    for (int c = 0; c < NV + LAT; c++) begin
      if (c < NV) issue(tab[c].op, tab[c].so, tab[c].a, tab[c].b, c, 1'b0);
      else idle();
      #1;
      if (c >= LAT) chk($sformatf("vec%0d", c - LAT), wb_data, tab[c - LAT].exp);
      tick();
    end
    wb_ack_ = 1'b1;
    for (int k = 0; k < 4; k++) begin
      issue(3'd0, 4'b0000, 64'(k), 64'd100, 20 + k, 1'b0);
      tick();
    end
    idle();
    #1;
    chk("busy_full", busy, 1'b1);
    tick();
    #1;
    chk("busy_hold", busy, 1'b1);
    chk("busy_head", wb_rob_id, 64'd20);
    wb_ack_ = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (k == 0) chk("busy_pop", busy, 1'b0);
      chk("drain_rob", wb_rob_id, 64'(20 + k));
      chk("drain_wb_e_", wb_e_, 1'b0);
      tick();
    end
    #1;
    chk("drained", wb_req_, 1'b1);
    wb_ack_ = 1'b1;
    for (int k = 0; k < 3; k++) begin
      issue(3'd1, 4'b0000, 64'd50, 64'(k), 8 + k, 1'b0);
      tick();
    end
    issue(3'd0, 4'b0000, 64'd1, 64'd1, 11, 1'b0);
    flush_ = 1'b0;
    wb_ack_ = 1'b0;
    #1;
    chk("flush_wb_e_", wb_e_, 1'b1);
    tick();
    flush_ = 1'b1;
    idle();
    for (int k = 0; k < LAT + 2; k++) begin
      #1;
      chk("flush_wb_req_", wb_req_, 1'b1);
      tick();
    end
    wb_ack_ = 1'b1;
    issue(3'd0, 4'b0000, 64'd7, 64'd7, 1, 1'b0);
    tick();
    issue(3'd0, 4'b0000, 64'd8, 64'd8, 2, 1'b0);
    tick();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wb_ack_ = 1'b0;
    for (int k = 0; k < LAT + 1; k++) begin
      #1;
      chk("midrst_wb_req_", wb_req_, 1'b1);
      tick();
    end
    for (int t = 0; t < 800; t++) begin
      wb_ack_ = $urandom_range(0, 3) < (t / 200);
      flush_ = $urandom_range(0, 49) != 0;
      reset = $urandom_range(0, 199) == 0;
      if ($urandom_range(0, 3) != 0 && !m_busy())
        issue(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), {$urandom(), $urandom()},
              $urandom_range(0, 1) != 0 ? 64'($urandom_range(0, 70)) : {$urandom(), $urandom()},
              int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      else idle();
      tick();
    end
    reset = 1'b0;
    flush_ = 1'b1;
    wb_ack_ = 1'b0;
    idle();
    repeat (LAT + WB + 2) tick();
    #1;
    chk("final_empty", wb_req_, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
